cacheline_adaptor: RTL

CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

---
 rtl/cacheline_adaptor.sv | 139 +++++++++++++
 1 files changed

// File: rtl/cacheline_adaptor.sv
// Bridges a cache line port to a narrow memory burst port.
// Fills assemble NB bursts into line_o. Writebacks stream a latched line out as NB bursts.
module cacheline_adaptor #(
  parameter int s_offset = 5,
  parameter int s_burst  = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [8*(2**s_offset)-1:0]    line_i,
  output logic [8*(2**s_offset)-1:0]    line_o,
  input  logic [31:0]                   address_i,
  input  logic                          read_i,
  input  logic                          write_i,
  output logic                          resp_o,
  input  logic [s_burst-1:0]            burst_i,
  output logic [s_burst-1:0]            burst_o,
  output logic [31:0]                   address_o,
  output logic                          read_o,
  output logic                          write_o,
  input  logic                          resp_i
);

  localparam int          s_line    = 8 * (2**s_offset);
  localparam int          NB        = s_line / s_burst;
  localparam int          CW        = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [31:0] ADDR_MASK = ~((32'd1 << s_offset) - 32'd1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CW-1:0]     r_cnt;
  logic [s_line-1:0] r_wbuf;
  logic [s_line-1:0] r_line;
  logic [31:0]       r_addr;
  logic              w_last;
  logic [CW-1:0]     w_cnt_inc;

  assign w_last    = (r_cnt == CW'(NB - 1));
  assign w_cnt_inc = w_last ? {CW{1'b0}} : (r_cnt + CW'(1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (write_i) begin
          w_next = WRITE;
        end else if (read_i) begin
          w_next = READ;
        end else begin
          w_next = IDLE;
        end
      end
      READ, WRITE: begin
        if (resp_i && w_last) begin
          w_next = DONE;
        end else begin
          w_next = r_state;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Request latching, burst capture into the fill line and burst counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= {CW{1'b0}};
      r_wbuf <= {s_line{1'b0}};
      r_line <= {s_line{1'b0}};
      r_addr <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (write_i) begin
            r_addr <= address_i & ADDR_MASK;
            r_wbuf <= line_i;
            r_cnt  <= {CW{1'b0}};
          end else if (read_i) begin
            r_addr <= address_i & ADDR_MASK;
            r_cnt  <= {CW{1'b0}};
          end
        end
        READ: begin
          if (resp_i) begin
            for (int k = 0; k < NB; k++) begin
              if (r_cnt == CW'(k)) begin
                r_line[k*s_burst +: s_burst] <= burst_i;
              end
            end
            r_cnt <= w_cnt_inc;
          end
        end
        WRITE: begin
          if (resp_i) begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  always_comb begin
    burst_o = {s_burst{1'b0}};
    if (r_state == WRITE) begin
      for (int k = 0; k < NB; k++) begin
        if (r_cnt == CW'(k)) begin
          burst_o = r_wbuf[k*s_burst +: s_burst];
        end
      end
    end else begin
      burst_o = {s_burst{1'b0}};
    end
  end

  assign read_o    = (r_state == READ);
  assign write_o   = (r_state == WRITE);
  assign resp_o    = (r_state == DONE);
  assign line_o    = r_line;
  assign address_o = r_addr;

endmodule
